// File: rtl/serializer_left.sv
// Parallel-to-serial converter, MSB first, built on a registered left shifter.
// One word in on a valid/ready port, one bit out per accepted serial beat.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no word held; parallel_ready=1, serial_valid=0
//   S_SHIFT | word in shift_q; MSB on serial_data, count_q = bits left - 1
module serializer_left #(
   parameter int         WIDTH     = 8,
   parameter logic [0:0] PAD_VALUE = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] parallel_data,
   input  logic             parallel_valid,
   output logic             parallel_ready,
   output logic             serial_data,
   output logic             serial_valid,
   input  logic             serial_ready,
   output logic             serial_last,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d, shifted;
   logic [CW-1:0]    count_q, count_d;
   logic             last, beat, accept;

   generate
      if (WIDTH == 1) begin : g_w1
         assign shifted = PAD_VALUE;
      end else begin : g_wn
         assign shifted = {shift_q[WIDTH-2:0], PAD_VALUE};
      end
   endgenerate

   assign last   = (state_q == S_SHIFT) && (count_q == '0);
   assign beat   = (state_q == S_SHIFT) && serial_ready;
   // Combinational ready lets a new word replace the last bit with no bubble.
   assign parallel_ready = !reset && ((state_q == S_IDLE) || (last && serial_ready));
   assign accept = parallel_ready && parallel_valid;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
      if (accept) begin
         state_d = S_SHIFT;
         shift_d = parallel_data;
         count_d = CNT_LOAD;
      end else if (beat) begin
         shift_d = shifted;
         if (last) begin
            state_d = S_IDLE;
         end else begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= {WIDTH{PAD_VALUE}};
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   assign serial_data  = shift_q[WIDTH-1];
   assign serial_valid = (state_q == S_SHIFT);
   assign busy         = (state_q == S_SHIFT);
   assign serial_last  = last;

endmodule

// File: tb/tb_serializer_left.sv
// Directed bench for serializer_left: 8-bit/pad 0, 1-bit/pad 1 and 4-bit/pad 1 instances.
module tb_serializer_left;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] pd8;
   logic       pv8 = 0, sr8 = 0;
   logic       pr8, sd8, sv8, sl8, bz8;

   logic [0:0] pd1;
   logic       pv1 = 0, sr1 = 0;
   logic       pr1, sd1, sv1, sl1, bz1;

   logic [3:0] pd4;
   logic       pv4 = 0, sr4 = 0;
   logic       pr4, sd4, sv4, sl4, bz4;

   serializer_left #(.WIDTH(8), .PAD_VALUE(1'b0)) dut_w8 (
      .clock(clock), .reset(reset),
      .parallel_data(pd8), .parallel_valid(pv8), .parallel_ready(pr8),
      .serial_data(sd8), .serial_valid(sv8), .serial_ready(sr8),
      .serial_last(sl8), .busy(bz8));

   serializer_left #(.WIDTH(1), .PAD_VALUE(1'b1)) dut_w1 (
      .clock(clock), .reset(reset),
      .parallel_data(pd1), .parallel_valid(pv1), .parallel_ready(pr1),
      .serial_data(sd1), .serial_valid(sv1), .serial_ready(sr1),
      .serial_last(sl1), .busy(bz1));

   serializer_left #(.WIDTH(4), .PAD_VALUE(1'b1)) dut_w4 (
      .clock(clock), .reset(reset),
      .parallel_data(pd4), .parallel_valid(pv4), .parallel_ready(pr4),
      .serial_data(sd4), .serial_valid(sv4), .serial_ready(sr4),
      .serial_last(sl4), .busy(bz4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Load one word into the 8-bit instance and check all eight beats plus the return to idle.
   task automatic run_word8(input logic [7:0] w);
      @(negedge clock);
      pv8 = 1; pd8 = w; sr8 = 1;
      #1 chk("w8_load_ready", pr8, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         pv8 = 0;
         #1;
         chk("w8_data", sd8, w[7-i]);
         chk("w8_last", sl8, (i == 7));
         chk("w8_valid", sv8, 1);
         chk("w8_ready", pr8, (i == 7));
      end
      @(negedge clock);
      #1;
      chk("w8_idle_valid", sv8, 0);
      chk("w8_idle_busy", bz8, 0);
      chk("w8_idle_ready", pr8, 1);
      chk("w8_idle_data", sd8, 0);
   endtask

   initial begin
      logic [15:0] stream;
      logic [7:0]  bp_word;

      pd8 = '0; pd1 = '0; pd4 = '0;

      // Reset
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1 chk("rst_ready_low", pr8, 0);
      reset = 0;
      #1;
      chk("rst_ready_high", pr8, 1);
      chk("rst_valid", sv8, 0);
      chk("rst_busy", bz8, 0);
      chk("rst_last", sl8, 0);
      chk("rst_data_pad0", sd8, 0);
      chk("rst_data_pad1_w1", sd1, 1);
      chk("rst_data_pad1_w4", sd4, 1);

      // Single word A5
      run_word8(8'hA5);

      // Back-to-back F0 then 0F with parallel_valid held
      stream = 16'hF00F;
      @(negedge clock);
      pv8 = 1; pd8 = 8'hF0; sr8 = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         pd8 = 8'h0F;
         pv8 = (i <= 7);
         #1;
         chk("b2b_data", sd8, stream[15-i]);
         chk("b2b_valid", sv8, 1);
         chk("b2b_last", sl8, (i == 7 || i == 15));
         chk("b2b_ready", pr8, (i == 7 || i == 15));
      end
      @(negedge clock);
      pv8 = 0;
      #1 chk("b2b_idle_valid", sv8, 0);

      // Backpressure on bit 2 of C3
      bp_word = 8'hC3;
      @(negedge clock);
      pv8 = 1; pd8 = bp_word; sr8 = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         pv8 = 0;
         if (i == 2) begin
            for (int k = 0; k < 3; k++) begin
               sr8 = 0;
               #1;
               chk("bp_hold_data", sd8, 0);
               chk("bp_hold_valid", sv8, 1);
               chk("bp_hold_last", sl8, 0);
               chk("bp_hold_ready", pr8, 0);
               @(negedge clock);
            end
         end
         sr8 = 1;
         #1;
         chk("bp_data", sd8, bp_word[7-i]);
         chk("bp_last", sl8, (i == 7));
      end
      @(negedge clock);
      #1 chk("bp_idle_valid", sv8, 0);

      // Reset after three beats of FF
      @(negedge clock);
      pv8 = 1; pd8 = 8'hFF; sr8 = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         pv8 = 0;
         #1 chk("mid_data", sd8, 1);
      end
      @(negedge clock);
      reset = 1;
      #1;
      chk("mid_rst_ready_low", pr8, 0);
      chk("mid_rst_valid_pre", sv8, 1);
      @(negedge clock);
      reset = 0;
      #1;
      chk("mid_rst_valid", sv8, 0);
      chk("mid_rst_busy", bz8, 0);
      chk("mid_rst_ready", pr8, 1);
      run_word8(8'h81);

      // WIDTH=1, PAD=1: words 1,0,1 back-to-back
      @(negedge clock);
      pv1 = 1; pd1 = 1'b1; sr1 = 1;
      #1 chk("w1_load_ready", pr1, 1);
      @(negedge clock);
      pd1 = 1'b0;
      #1;
      chk("w1_b0_data", sd1, 1);
      chk("w1_b0_last", sl1, 1);
      chk("w1_b0_ready", pr1, 1);
      @(negedge clock);
      pd1 = 1'b1;
      #1;
      chk("w1_b1_data", sd1, 0);
      chk("w1_b1_last", sl1, 1);
      chk("w1_b1_valid", sv1, 1);
      @(negedge clock);
      pv1 = 0;
      #1;
      chk("w1_b2_data", sd1, 1);
      chk("w1_b2_last", sl1, 1);
      @(negedge clock);
      #1;
      chk("w1_idle_valid", sv1, 0);
      chk("w1_idle_data_pad", sd1, 1);

      // WIDTH=4, PAD=1: word 8, no follow-on; four pad shifts leave all ones
      @(negedge clock);
      pv4 = 1; pd4 = 4'h8; sr4 = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         pv4 = 0;
         #1;
         chk("w4_data", sd4, (i == 0));
         chk("w4_last", sl4, (i == 3));
      end
      @(negedge clock);
      #1;
      chk("w4_idle_valid", sv4, 0);
      chk("w4_idle_busy", bz4, 0);
      chk("w4_idle_shift", dut_w4.shift_q, 4'hF);
      chk("w4_idle_ready", pr4, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
